register_file: RTL and testbench

// - 32 x 32-bit general-purpose register file for the single-cycle datapath.
// - Sits directly upstream of the 32-bit 2:1 operand mux (ALUSrc).
// - ReadData2 feeds mux input I0, with the sign-extended immediate on I1.
// - ReadData1 feeds the ALU A operand directly.
// - Two combinational read ports, one synchronous write port, register 0

---
 rtl/register_file_if.sv | 28 ++
 rtl/register_file.sv | 74 +++++++
 tb/tb_register_file.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Bus bundle between the datapath controller and the register file:
// the write port, the two operand read ports, the debug read port and the write counter.
interface register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] DbgReg;
  logic [DATA_W-1:0] DbgData;
  logic [CNT_W-1:0]  WriteCount;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
    input  ReadData1, ReadData2, DbgData, WriteCount
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
    output ReadData1, ReadData2, DbgData, WriteCount
  );
endinterface

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 = 0,
// saturating committed-write counter. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  register_file_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              commit_c;
  logic [DATA_W-1:0] arr1_c;
  logic [DATA_W-1:0] arr2_c;
  logic [DATA_W-1:0] arrd_c;

  // A write commits only when enabled and not aimed at the hardwired-zero register
  assign commit_c = bus.RegWrite && (bus.WriteReg != '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_c) begin
      regs_q[bus.WriteReg] <= bus.WriteData;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (commit_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Index 0 is forced to zero on read so its storage never matters
  assign arr1_c = (bus.ReadReg1 == '0) ? '0 : regs_q[bus.ReadReg1];
  assign arr2_c = (bus.ReadReg2 == '0) ? '0 : regs_q[bus.ReadReg2];
  assign arrd_c = (bus.DbgReg   == '0) ? '0 : regs_q[bus.DbgReg];

`ifdef REGFILE_BYPASS_EN
  logic byp1_c;
  logic byp2_c;

  // Forwarding is gated by reset so reads stay zero while the array is held clear
  assign byp1_c = Rst_n && commit_c && (bus.ReadReg1 == bus.WriteReg);
  assign byp2_c = Rst_n && commit_c && (bus.ReadReg2 == bus.WriteReg);

  assign bus.ReadData1 = byp1_c ? bus.WriteData : arr1_c;
  assign bus.ReadData2 = byp2_c ? bus.WriteData : arr2_c;
`else
  assign bus.ReadData1 = arr1_c;
  assign bus.ReadData2 = arr2_c;
`endif

  assign bus.DbgData    = arrd_c;
  assign bus.WriteCount = cnt_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps followed by random traffic, checked
// against an array model; a second instance with a 4-bit counter sees the same traffic.
module tb_register_file;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic Clk;
  logic Rst_n;

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) bus ();
  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))  sat_if ();

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_sat (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (sat_if.slave)
  );

  assign sat_if.RegWrite  = bus.RegWrite;
  assign sat_if.WriteReg  = bus.WriteReg;
  assign sat_if.WriteData = bus.WriteData;
  assign sat_if.ReadReg1  = bus.ReadReg1;
  assign sat_if.ReadReg2  = bus.ReadReg2;
  assign sat_if.DbgReg    = bus.DbgReg;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain array of register contents and a count of committed writes
  logic [31:0] model_regs [32];
  int unsigned model_commits;
  int unsigned n_pass;
  int unsigned n_total;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit bypass_ok);
    if (bypass_ok && Rst_n && bus.RegWrite && bus.WriteReg != 5'd0 && idx == bus.WriteReg)
      return bus.WriteData;
    if (!Rst_n || idx == 5'd0) return 32'd0;
    return model_regs[idx];
  endfunction

  function automatic logic [31:0] sat_exp(input int unsigned n, input int unsigned max_v);
    return (n > max_v) ? 32'(max_v) : 32'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_commits = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd1"}, bus.ReadData1, exp_read(bus.ReadReg1, BYPASS));
    check({tag, ".rd2"}, bus.ReadData2, exp_read(bus.ReadReg2, BYPASS));
    check({tag, ".dbg"}, bus.DbgData, exp_read(bus.DbgReg, 1'b0));
    check({tag, ".cnt"}, 32'(bus.WriteCount), sat_exp(model_commits, 65535));
    check({tag, ".sat"}, 32'(sat_if.WriteCount), sat_exp(model_commits, 15));
  endtask

  // One clock cycle: drive at negedge, check before the edge, update the model after it
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] dbg);
    bus.RegWrite  = we;
    bus.WriteReg  = wa;
    bus.WriteData = wd;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
    bus.DbgReg    = dbg;
    #1;
    check_outputs(tag);
    @(posedge Clk);
    if (we && wa != 5'd0) begin
      model_regs[wa] = wd;
      model_commits++;
    end
    @(negedge Clk);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    model_reset();
    Rst_n = 1'b0;
    bus.RegWrite = 1'b0;
    bus.WriteReg = 5'd0;
    bus.WriteData = 32'd0;
    bus.ReadReg1 = 5'd5;
    bus.ReadReg2 = 5'd7;
    bus.DbgReg = 5'd31;
    #12;
    check("reset.rd1", bus.ReadData1, 32'd0);
    check("reset.rd2", bus.ReadData2, 32'd0);
    check("reset.dbg", bus.DbgData, 32'd0);
    check("reset.cnt", 32'(bus.WriteCount), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Basic write then read on both ports
    cycle("wr_r5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    cycle("rd_r5", 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    check("r5.value", bus.ReadData1, 32'hDEADBEEF);
    check("r5.count", 32'(bus.WriteCount), 32'd1);

    // Writes to r0 are dropped and do not count
    cycle("wr_r0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    cycle("rd_r0", 1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    check("r0.value", bus.ReadData1, 32'd0);
    check("r0.count", 32'(bus.WriteCount), 32'd1);

    // Same-cycle read of the write target
    cycle("pre_r7", 1'b1, 5'd7, 32'hAAAA5555, 5'd0, 5'd0, 5'd0);
    bus.RegWrite = 1'b1; bus.WriteReg = 5'd7; bus.WriteData = 32'h12345678;
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd7; bus.DbgReg = 5'd7;
    #1;
    check("same.rd2", bus.ReadData2, BYPASS ? 32'h12345678 : 32'hAAAA5555);
    check("same.dbg", bus.DbgData, 32'hAAAA5555);
    @(posedge Clk);
    model_regs[7] = 32'h12345678;
    model_commits++;
    @(negedge Clk);
    cycle("post_r7", 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);

    // Reset falling mid-cycle during a write: outputs clear at once and reset wins at the edge
    bus.RegWrite = 1'b1; bus.WriteReg = 5'd9; bus.WriteData = 32'hCAFEF00D;
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd7; bus.DbgReg = 5'd9;
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.rd1", bus.ReadData1, 32'd0);
    check("midrst.rd2", bus.ReadData2, 32'd0);
    check("midrst.cnt", 32'(bus.WriteCount), 32'd0);
    @(posedge Clk);
    #1;
    check("midrst.r9", bus.DbgData, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Full sweep r1..r31, then read every index through the debug port
    for (int i = 1; i < 32; i++)
      cycle("sweep_wr", 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i - 1), 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      cycle("sweep_rd", 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'(i));
      check("sweep.lit", bus.DbgData, 32'(i) * 32'h01010101);
    end
    check("sweep.count", 32'(bus.WriteCount), 32'd31);
    check("sat.count", 32'(sat_if.WriteCount), 32'd15);

    // Random traffic, with occasional reads aimed at the write target
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [4:0]  wa;
      logic [4:0]  r1;
      logic [4:0]  r2;
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle("rand", we, wa, $urandom(), r1, r2, 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
